// File: rtl/cnn_pkg.sv
// cnn_pkg: shared types for the CNN job dispatcher.
// Holds the FSM state encoding and the job descriptor layout.
package cnn_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        REPORT
    } state_t;

    localparam int AW_MAX = 32;

    function automatic int aw_of(input int kernel_count);
        return $clog2(kernel_count * 16 + 256);
    endfunction

    // Fields sized for the widest supported CNN; bits above AW stay zero.
    typedef struct packed {
        logic [AW_MAX-1:0] x;
        logic [AW_MAX-1:0] y;
        logic [7:0]        z;
    } job_t;

endpackage

// File: rtl/job_fifo.sv
// job_fifo: registered descriptor queue with full/empty flags.
// Pointers carry one wrap bit so full and empty are distinguishable.
module job_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      wp;
    logic [PW:0]      rp;
    logic             wr;
    logic             rd;

    assign wr    = push && !full;
    assign rd    = pop && !empty;
    assign empty = (wp == rp);
    assign full  = (wp[PW] != rp[PW]) &&
                   (wp[PW-1:0] == rp[PW-1:0]);
    assign dout  = mem[rp[PW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (wr) wp <= wp + (PW+1)'(1);
            if (rd) rp <= rp + (PW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem[wp[PW-1:0]] <= din;
    end

endmodule

// File: rtl/cnn_job_dispatcher.sv
// cnn_job_dispatcher: queues job descriptors and runs them one at a
// time on the CNN, reporting each completion or timeout abort.
module cnn_job_dispatcher
    import cnn_pkg::*;
#(
    parameter int  KERNEL_COUNT = 4,
    parameter int  FIFO_DEPTH   = 4,
    parameter int  TIMEOUT      = 1023,
    localparam int AW           = aw_of(KERNEL_COUNT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          job_valid,
    output logic          job_ready,
    input  logic [AW-1:0] job_x,
    input  logic [AW-1:0] job_y,
    input  logic [7:0]    job_z,
    output logic          cnn_start,
    output logic [AW-1:0] cnn_x,
    output logic [AW-1:0] cnn_y,
    output logic [7:0]    cnn_z,
    input  logic          cnn_done,
    output logic          cmp_valid,
    input  logic          cmp_ready,
    output logic [7:0]    cmp_z,
    output logic          cmp_timeout,
    output logic          busy
);

    localparam int FW = 2 * AW + 8;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic          tmo;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [FW-1:0] din;
    logic [FW-1:0] dout;
    job_t          head;
    job_t          cur;
    logic          unused_hi;

    assign push      = job_valid && !full;
    assign job_ready = !full;
    assign din       = {job_x, job_y, job_z};
    assign head      = {AW_MAX'(dout[FW-1 -: AW]),
                        AW_MAX'(dout[AW+7 -: AW]),
                        dout[7:0]};
    assign cnt_inc   = cnt + CW'(1);

    job_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (din),
        .pop   (pop),
        .dout  (dout),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        pop     = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_n = START;
                end
            end
            START: state_n = WAIT;
            WAIT: begin
                if (cnn_done || cnt_inc == LIMIT)
                    state_n = REPORT;
            end
            REPORT: begin
                if (cmp_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Done has priority over the limit, so a late done still counts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur <= '0;
            cnt <= '0;
            tmo <= 1'b0;
        end else begin
            if (pop) cur <= head;
            if (state == START) begin
                cnt <= '0;
                tmo <= 1'b0;
            end else if (state == WAIT && !cnn_done) begin
                cnt <= cnt_inc;
                tmo <= (cnt_inc == LIMIT);
            end
        end
    end

    assign cnn_start   = (state == START);
    assign cmp_valid   = (state == REPORT);
    assign cmp_timeout = cmp_valid && tmo;
    assign busy        = (state != IDLE);
    assign cnn_x       = cur.x[AW-1:0];
    assign cnn_y       = cur.y[AW-1:0];
    assign cnn_z       = cur.z;
    assign cmp_z       = cur.z;
    assign unused_hi   = |{cur.x, cur.y};

endmodule

// File: tb/tb_cnn_job_dispatcher.sv
// tb_cnn_job_dispatcher: directed vector table plus hand-written
// multi-cycle sequences for queueing, timeout, backpressure and reset.
module tb_cnn_job_dispatcher;

    localparam int AW = 9;

    logic          clk;
    logic          rst;
    logic          job_valid;
    logic          job_ready;
    logic [AW-1:0] job_x;
    logic [AW-1:0] job_y;
    logic [7:0]    job_z;
    logic          cnn_start;
    logic [AW-1:0] cnn_x;
    logic [AW-1:0] cnn_y;
    logic [7:0]    cnn_z;
    logic          cnn_done;
    logic          cmp_valid;
    logic          cmp_ready;
    logic [7:0]    cmp_z;
    logic          cmp_timeout;
    logic          busy;

    int n_cmp = 0;
    int n_bad = 0;

    cnn_job_dispatcher #(
        .KERNEL_COUNT (4),
        .FIFO_DEPTH   (4),
        .TIMEOUT      (15)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .job_valid   (job_valid),
        .job_ready   (job_ready),
        .job_x       (job_x),
        .job_y       (job_y),
        .job_z       (job_z),
        .cnn_start   (cnn_start),
        .cnn_x       (cnn_x),
        .cnn_y       (cnn_y),
        .cnn_z       (cnn_z),
        .cnn_done    (cnn_done),
        .cmp_valid   (cmp_valid),
        .cmp_ready   (cmp_ready),
        .cmp_z       (cmp_z),
        .cmp_timeout (cmp_timeout),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          v;
        logic [AW-1:0] x;
        logic [AW-1:0] y;
        logic [7:0]    z;
        logic          done;
        logic          rdy;
        logic          e_jr;
        logic          e_st;
        logic          e_busy;
        logic          e_cv;
        logic          e_to;
        logic [7:0]    e_cz;
        logic [AW-1:0] e_cy;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(
        input logic v, input logic [AW-1:0] x,
        input logic [AW-1:0] y, input logic [7:0] z,
        input logic done, input logic rdy,
        input logic e_jr, input logic e_st,
        input logic e_busy, input logic e_cv,
        input logic e_to, input logic [7:0] e_cz,
        input logic [AW-1:0] e_cy);
        vec_t r;
        r.v = v; r.x = x; r.y = y; r.z = z;
        r.done = done; r.rdy = rdy;
        r.e_jr = e_jr; r.e_st = e_st;
        r.e_busy = e_busy; r.e_cv = e_cv;
        r.e_to = e_to; r.e_cz = e_cz; r.e_cy = e_cy;
        tbl.push_back(r);
    endfunction

    function automatic logic [AW-1:0] xof(input logic [7:0] z);
        return AW'(z * 3);
    endfunction

    function automatic logic [AW-1:0] yof(input logic [7:0] z);
        return {1'b1, z};
    endfunction

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h",
                     nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_job(input logic [7:0] z);
        int n = 0;
        job_valid = 1'b1;
        job_x = xof(z);
        job_y = yof(z);
        job_z = z;
        while (!job_ready && n < 30) begin
            tick();
            n++;
        end
        chk("push_ready", job_ready, 1);
        tick();
        job_valid = 1'b0;
    endtask

    task automatic wait_start(input logic [7:0] z);
        int n = 0;
        while (!cnn_start && n < 10) begin
            tick();
            n++;
        end
        chk("start_seen", cnn_start, 1);
        chk("start_z", cnn_z, z);
        chk("start_x", cnn_x, xof(z));
    endtask

    task automatic serve(input logic [7:0] z, input int dly);
        repeat (dly) tick();
        cnn_done = 1'b1;
        tick();
        cnn_done = 1'b0;
        chk("rep_valid", cmp_valid, 1);
        chk("rep_z", cmp_z, z);
        chk("rep_tmo", cmp_timeout, 0);
        chk("rep_y_stable", cnn_y, yof(z));
        cmp_ready = 1'b1;
        tick();
        cmp_ready = 1'b0;
        chk("rep_released", cmp_valid, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b0;
        job_valid = 1'b0;
        job_x = '0;
        job_y = '0;
        job_z = '0;
        cnn_done = 1'b0;
        cmp_ready = 1'b0;

        // reset state
        #3;
        chk("rst_start", cnn_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cv", cmp_valid, 0);
        chk("rst_y", cnn_y, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        tick();
        chk("rel_ready", job_ready, 1);
        chk("rel_busy", busy, 0);

        // single job trace, done 10 cycles after start
        add(1, 0, 9'h10C, 0, 0, 0, 1, 0, 0, 0, 0, 0, 9'h000);
        add(0, 0, 0, 0, 1, 0, 1, 1, 1, 0, 0, 0, 9'h10C);
        add(0, 0, 0, 0, 1, 0, 1, 0, 1, 0, 0, 0, 9'h10C);
        for (int k = 3; k < 12; k++)
            add(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 9'h10C);
        add(0, 0, 0, 0, 1, 0, 1, 0, 1, 1, 0, 0, 9'h10C);
        add(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 9'h10C);
        add(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 9'h10C);

        foreach (tbl[i]) begin
            job_valid = tbl[i].v;
            job_x = tbl[i].x;
            job_y = tbl[i].y;
            job_z = tbl[i].z;
            cnn_done = tbl[i].done;
            cmp_ready = tbl[i].rdy;
            tick();
            chk($sformatf("v%0d_jr", i), job_ready, tbl[i].e_jr);
            chk($sformatf("v%0d_st", i), cnn_start, tbl[i].e_st);
            chk($sformatf("v%0d_bz", i), busy, tbl[i].e_busy);
            chk($sformatf("v%0d_cv", i), cmp_valid, tbl[i].e_cv);
            chk($sformatf("v%0d_to", i), cmp_timeout, tbl[i].e_to);
            chk($sformatf("v%0d_cz", i), cmp_z, tbl[i].e_cz);
            chk($sformatf("v%0d_cy", i), cnn_y, tbl[i].e_cy);
        end
        job_valid = 1'b0;
        cnn_done = 1'b0;
        cmp_ready = 1'b0;

        // fill queue behind an in-flight job; fifth push must stall
        push_job(8'hA0);
        for (int z = 1; z <= 4; z++) push_job(8'(z));
        job_valid = 1'b1;
        job_x = xof(8'd5);
        job_y = yof(8'd5);
        job_z = 8'd5;
        chk("full_ready0", job_ready, 0);
        tick();
        chk("full_ready1", job_ready, 0);
        tick();
        chk("full_ready2", job_ready, 0);
        cnn_done = 1'b1;
        tick();
        cnn_done = 1'b0;
        chk("blk_valid", cmp_valid, 1);
        chk("blk_z", cmp_z, 8'hA0);
        cmp_ready = 1'b1;
        tick();
        cmp_ready = 1'b0;
        chk("m1_ready", job_ready, 0);
        chk("m1_start", cnn_start, 0);
        tick();
        chk("m2_start", cnn_start, 1);
        chk("m2_z", cnn_z, 1);
        chk("m2_ready", job_ready, 1);
        tick();
        job_valid = 1'b0;
        serve(8'd1, 1);
        for (int z = 2; z <= 5; z++) begin
            wait_start(8'(z));
            serve(8'(z), 2);
        end

        // timeout abort, then next job with done at the limit cycle
        push_job(8'h33);
        push_job(8'h34);
        wait_start(8'h33);
        n = 0;
        while (!cmp_valid && n < 40) begin
            tick();
            n++;
        end
        chk("tmo_latency", n, 16);
        chk("tmo_flag", cmp_timeout, 1);
        chk("tmo_z", cmp_z, 8'h33);
        cmp_ready = 1'b1;
        tick();
        cmp_ready = 1'b0;
        wait_start(8'h34);
        repeat (15) tick();
        chk("lim_not_yet", cmp_valid, 0);
        cnn_done = 1'b1;
        tick();
        cnn_done = 1'b0;
        chk("lim_valid", cmp_valid, 1);
        chk("lim_tmo", cmp_timeout, 0);
        cmp_ready = 1'b1;
        tick();
        cmp_ready = 1'b0;

        // completion backpressure with two jobs queued
        push_job(8'h41);
        push_job(8'h42);
        push_job(8'h43);
        chk("bp_busy", busy, 1);
        chk("bp_z", cnn_z, 8'h41);
        cnn_done = 1'b1;
        tick();
        cnn_done = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp%0d_cv", k), cmp_valid, 1);
            chk($sformatf("bp%0d_cz", k), cmp_z, 8'h41);
            chk($sformatf("bp%0d_st", k), cnn_start, 0);
            tick();
        end
        cmp_ready = 1'b1;
        tick();
        cmp_ready = 1'b0;
        chk("bp_m1_start", cnn_start, 0);
        tick();
        chk("bp_m2_start", cnn_start, 1);
        chk("bp_m2_z", cnn_z, 8'h42);
        serve(8'h42, 1);
        wait_start(8'h43);
        serve(8'h43, 1);

        // reset mid-WAIT with three jobs queued
        push_job(8'h51);
        push_job(8'h52);
        push_job(8'h53);
        push_job(8'h54);
        chk("mr_busy", busy, 1);
        chk("mr_z", cnn_z, 8'h51);
        #2;
        rst = 1'b0;
        #1;
        chk("mr_start", cnn_start, 0);
        chk("mr_cv", cmp_valid, 0);
        chk("mr_to", cmp_timeout, 0);
        chk("mr_busy0", busy, 0);
        chk("mr_x0", cnn_x, 0);
        chk("mr_y0", cnn_y, 0);
        chk("mr_z0", cnn_z, 0);
        chk("mr_cz0", cmp_z, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk($sformatf("pr%0d_st", k), cnn_start, 0);
        end
        chk("pr_busy", busy, 0);
        chk("pr_ready", job_ready, 1);
        chk("pr_cv", cmp_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cnn_job_dispatcher.md
CNN_JOB_DISPATCHER -- requirements
Module: cnn_job_dispatcher

Interface
REQ-001 SHALL have parameter KERNEL_COUNT, default 4, number of kernels of the driven cnn; AW = $clog2(KERNEL_COUNT*16+256).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, job descriptor queue depth (power of 2, >=2).
REQ-003 SHALL have parameter TIMEOUT, default 1023, maximum WAIT cycles before abort.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 job_valid  in  1  job descriptor offered.
REQ-007 job_ready  out  1  descriptor accepted when job_valid & job_ready.
REQ-008 job_x  in  AW  input feature base address.
REQ-009 job_y  in  AW  kernel base address.
REQ-010 job_z  in  8  output base address.
REQ-011 cnn_start  out  1  one-cycle start pulse to cnn.
REQ-012 cnn_x / cnn_y  out  AW each  addresses to cnn.
REQ-013 cnn_z  out  8  output address to cnn.
REQ-014 cnn_done  in  1  cnn completion.
REQ-015 cmp_valid  out  1  completion record available.
REQ-016 cmp_ready  in  1  completion consumed when cmp_valid & cmp_ready.
REQ-017 cmp_z  out  8  cnn_z of completed job; cmp_timeout  out  1  job aborted by timeout.
REQ-018 busy  out  1  high whenever state != IDLE.

Function
REQ-019 SHALL buffer descriptors {x,y,z} in a FIFO_DEPTH-entry FIFO; job_ready = !full; no push when full, even if a pop occurs that cycle.
REQ-020 SHALL implement FSM IDLE -> START -> WAIT -> REPORT -> IDLE.
REQ-021 IDLE: if FIFO non-empty, pop head into cnn_x/cnn_y/cnn_z registers and go to START; else stay.
REQ-022 START: cnn_start=1 for exactly this one cycle; next state WAIT; wait counter cleared to 0.
REQ-023 cnn_x/cnn_y/cnn_z SHALL remain stable from START through end of REPORT.
REQ-024 WAIT: cnn_done sampled only here; cnn_done=1 -> REPORT with cmp_timeout=0.
REQ-025 WAIT: counter increments each cycle without done; counter reaching TIMEOUT with cnn_done=0 -> REPORT with cmp_timeout=1; done in same cycle as limit wins (cmp_timeout=0).
REQ-026 REPORT: cmp_valid=1, cmp_z=cnn_z; hold until cmp_ready=1, then IDLE; no new start issued while in REPORT.
REQ-027 Latency: job accepted into empty FIFO at cycle N (state IDLE) -> cnn_start=1 at cycle N+2.
REQ-028 Back-to-back: with queued jobs, REPORT handshake at cycle M -> next cnn_start at M+2.
REQ-029 cnn_done in IDLE, START or REPORT SHALL be ignored.
REQ-030 Counter width $clog2(TIMEOUT+1); SHALL never wrap.

Reset
REQ-031 rst=0 asynchronously: state IDLE, FIFO empty, counter 0; job_ready=1 after release; cnn_start, cmp_valid, cmp_timeout, busy = 0; cnn_x, cnn_y, cmp_z, cnn_z = 0.
REQ-032 Reset mid-WAIT SHALL discard the in-flight job and all queued jobs; no completion reported.

Structure
REQ-033 Shared package cnn_pkg SHALL hold the state enum (IDLE, START, WAIT, REPORT) and the job descriptor struct type; AW function of KERNEL_COUNT there.
REQ-034 Sub-module job_fifo (parameterised width/depth, registered, full/empty flags) SHALL hold descriptors; FSM and timeout counter in top.

Verification
REQ-035 Single job x=0, y=0x10C, z=0; cnn_done pulsed 10 cycles after start -> cnn_start one cycle at N+2, cnn_y=0x10C, cmp_valid with cmp_z=0, cmp_timeout=0.
REQ-036 Push 5 jobs (z=1..5) back-to-back, cnn_done held 0 -> 4 accepted, job_ready=0 on fifth until first pop; all 5 eventually reported in order z=1..5 once done pulses supplied.
REQ-037 TIMEOUT=15, cnn_done never asserted -> cmp_valid with cmp_timeout=1 after 15 WAIT cycles; next queued job then starts.
REQ-038 cnn_done coincident with counter=TIMEOUT -> cmp_timeout=0.
REQ-039 cmp_ready held 0 for 5 cycles in REPORT with 2 jobs queued -> cmp_valid/cmp_z stable, no cnn_start until handshake, then start at M+2.
REQ-040 rst=0 asserted mid-WAIT with 3 queued jobs -> all outputs 0 immediately; after release, no cnn_start, busy=0, job_ready=1.
